exmem_skid_buf: RTL and testbench

Parametrised EX/MEM pipeline buffer carrying L data lanes plus one control word from the execute stage to the memory stage. It uses a valid/ready handshake with a two-entry skid buffer, so the memory stage can stall without a combinational ready path back into execute. It adds synchronous flush for branch/exception squash and an occupancy count. The optional byte-truncated last lane carries the store byte.

---
 rtl/exmem_skid_buf_if.sv | 26 ++
 rtl/exmem_skid_buf.sv | 118 +++++++++++
 tb/tb_exmem_skid_buf.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/exmem_skid_buf_if.sv
// EX/MEM handshake bundle: valid/ready plus lane data and control word.
// The producer side uses master and the consumer side uses slave.
interface exmem_skid_buf_if #(
  parameter int W  = 16,
  parameter int L  = 4,
  parameter int CW = 16
);
  logic           valid;
  logic           ready;
  logic [L*W-1:0] data;
  logic [CW-1:0]  ctrl;

  modport master (
    output valid,
    output data,
    output ctrl,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  ctrl,
    output ready
  );
endinterface

// File: rtl/exmem_skid_buf.sv
// EX/MEM two-entry skid buffer with squash flush and occupancy count.
// Every output is decoded from flops only, so ready never ripples back.
module exmem_skid_buf #(
  parameter int W         = 16,
  parameter int L         = 4,
  parameter int CW        = 16,
  parameter bit BYTE_LAST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  exmem_skid_buf_if.slave       in_if,
  exmem_skid_buf_if.master      out_if,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [L*W-1:0] m_data_q, m_data_d;
  logic [CW-1:0]  m_ctrl_q, m_ctrl_d;
  logic [L*W-1:0] s_data_q, s_data_d;
  logic [CW-1:0]  s_ctrl_q, s_ctrl_d;

  logic           m_valid;
  logic           s_valid;
  logic           acc;
  logic           pop;
  logic [L*W-1:0] in_mask;

  assign m_valid      = (state_q != EMPTY);
  assign s_valid      = (state_q == FULL);
  assign in_if.ready  = !s_valid;
  assign out_if.valid = m_valid;
  assign out_if.data  = m_data_q;
  assign out_if.ctrl  = m_ctrl_q;
  assign occupancy    = {1'b0, m_valid} + {1'b0, s_valid};

  assign acc = in_if.valid & !s_valid;
  assign pop = m_valid & out_if.ready;

  // Store lane keeps only its low byte when the last lane is byte-wide.
  always_comb begin
    in_mask = in_if.data;
    if (BYTE_LAST) begin
      for (int b = 8; b < W; b++) begin
        in_mask[(L-1)*W+b] = 1'b0;
      end
    end
  end

  // Next-state and register loads; flush squashes everything.
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          m_data_d = in_mask;
          m_ctrl_d = in_if.ctrl;
          state_d  = ONE;
        end
      end
      ONE: begin
        if (acc && pop) begin
          m_data_d = in_mask;
          m_ctrl_d = in_if.ctrl;
        end else if (acc) begin
          s_data_d = in_mask;
          s_ctrl_d = in_if.ctrl;
          state_d  = FULL;
        end else if (pop) begin
          state_d  = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          m_data_d = s_data_q;
          m_ctrl_d = s_ctrl_q;
          state_d  = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d  = EMPTY;
      m_data_d = '0;
      m_ctrl_d = '0;
      s_data_d = '0;
      s_ctrl_d = '0;
    end
  end

  // State and entry registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= EMPTY;
      m_data_q <= '0;
      m_ctrl_q <= '0;
      s_data_q <= '0;
      s_ctrl_q <= '0;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      m_ctrl_q <= m_ctrl_d;
      s_data_q <= s_data_d;
      s_ctrl_q <= s_ctrl_d;
    end
  end

endmodule

// File: tb/tb_exmem_skid_buf.sv
// Bench for exmem_skid_buf: queue scoreboard of accepted entries,
// checked against occupancy, handshake flags and popped data.
module tb_exmem_skid_buf;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] occupancy;

  exmem_skid_buf_if #(.W(16), .L(4), .CW(16)) in_if ();
  exmem_skid_buf_if #(.W(16), .L(4), .CW(16)) out_if ();

  exmem_skid_buf #(
    .W(16), .L(4), .CW(16), .BYTE_LAST(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_if     (in_if),
    .out_if    (out_if),
    .occupancy (occupancy)
  );

  int checks = 0;
  int errors = 0;

  logic [79:0] q[$];
  logic        zero_exp  = 1'b0;
  logic        hold_exp  = 1'b0;
  logic [63:0] hold_data = '0;
  logic [15:0] hold_ctrl = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mask(input logic [63:0] d);
    logic [63:0] r;
    r = d;
    r[63:56] = 8'h00;
    return r;
  endfunction

  task automatic cyc(input logic        v,
                     input logic [63:0] d,
                     input logic [15:0] c,
                     input logic        ordy,
                     input logic        fl,
                     input logic        rs);
    logic [79:0] e;
    @(negedge clk);
    chk("occupancy", {62'd0, occupancy}, 64'(q.size()));
    chk("in_ready", {63'd0, in_if.ready}, {63'd0, q.size() < 2});
    chk("out_valid", {63'd0, out_if.valid}, {63'd0, q.size() != 0});
    if (zero_exp) begin
      chk("zero_data", out_if.data, 64'd0);
      chk("zero_ctrl", {48'd0, out_if.ctrl}, 64'd0);
    end
    if (hold_exp) begin
      chk("hold_data", out_if.data, hold_data);
      chk("hold_ctrl", {48'd0, out_if.ctrl}, {48'd0, hold_ctrl});
    end
    in_if.valid  = v;
    in_if.data   = d;
    in_if.ctrl   = c;
    out_if.ready = ordy;
    flush        = fl;
    rst          = rs;
    hold_exp  = rs && !fl && out_if.valid && !ordy;
    hold_data = out_if.data;
    hold_ctrl = out_if.ctrl;
    zero_exp  = !rs || fl;
    if (!rs) begin
      q.delete();
    end else begin
      if (out_if.valid && ordy) begin
        if (q.size() == 0) begin
          chk("pop_empty", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("pop_data", out_if.data, e[79:16]);
          chk("pop_ctrl", {48'd0, out_if.ctrl}, {48'd0, e[15:0]});
        end
      end
      if (fl) q.delete();
      else if (v && in_if.ready) q.push_back({mask(d), c});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 64'd0, 16'd0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    rst          = 1'b0;
    flush        = 1'b0;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    in_if.ctrl   = '0;
    out_if.ready = 1'b0;

    // reset held with input offered
    cyc(1'b1, 64'h1111_2222_3333_4444, 16'h00AA, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h1111_2222_3333_4444, 16'h00AA, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 64'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 64'd0, 16'd0, 1'b0, 1'b0, 1'b1);

    // streaming
    for (int i = 1; i <= 8; i++)
      cyc(1'b1, {16'(i), 16'h00C0, 16'(i * 3), 16'h0F00},
          16'(i), 1'b1, 1'b0, 1'b1);
    idle(2);

    // backpressure
    cyc(1'b1, 64'hA0A0_A1A1_A2A2_A3A3, 16'h000A, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 64'hB0B0_B1B1_B2B2_B3B3, 16'h000B, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 64'hC0C0_C1C1_C2C2_C3C3, 16'h000C, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 64'hC0C0_C1C1_C2C2_C3C3, 16'h000C, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 64'hC0C0_C1C1_C2C2_C3C3, 16'h000C, 1'b1, 1'b0, 1'b1);
    idle(3);

    // byte lane truncation
    cyc(1'b1, 64'hBEEF_9ABC_5678_1234, 16'h0033, 1'b1, 1'b0, 1'b1);
    idle(2);

    // flush while full, with input and pop offered
    cyc(1'b1, 64'h0101_0202_0303_0404, 16'h0051, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 64'h0505_0606_0707_0808, 16'h0052, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 64'hDEAD_DEAD_DEAD_DEAD, 16'h0053, 1'b1, 1'b1, 1'b1);
    idle(3);

    // reset mid-stream during an accept
    cyc(1'b1, 64'h7777_6666_5555_4444, 16'h0061, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 64'h8888_9999_AAAA_BBBB, 16'h0062, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 64'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, {48'h1357_2468_ACE0, 16'(i)}, 16'(16'h70 + i),
          1'b1, 1'b0, 1'b1);
    idle(2);

    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)),
          {$urandom, $urandom}, 16'($urandom),
          1'($urandom_range(0, 2) != 0),
          $urandom_range(0, 15) == 0,
          $urandom_range(0, 49) != 0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
